// File: rtl/priority_arb_n.sv
// priority_arb_n: N-input priority arbiter with a registered grant and a
// valid/ready handoff toward one downstream consumer. Fixed priority
// (highest index wins) or rotating priority, chosen by ROUND_ROBIN.
//
// Handshake: valid is high whenever a grant is presented. The grant
// (idx/grant) is frozen while valid is high and is consumed on any rising
// edge where valid & out_ready. On that same edge a new winner is loaded if
// en & |req; otherwise valid drops on the following cycle. A grant is never
// withdrawn before it is consumed, except by rst.
module priority_arb_n #(
    parameter int N           = 8,
    parameter bit ROUND_ROBIN = 1'b0,
    localparam int W          = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         valid,
    output logic [W-1:0] idx,
    output logic [N-1:0] grant,
    output logic         o_dbg_state,
    output logic [W-1:0] o_dbg_ptr
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [W-1:0]   r_idx;
    logic [N-1:0]   r_grant;
    logic [W-1:0]   r_ptr;

    logic [W-1:0]   w_ptr_eff;
    logic [W-1:0]   w_win;
    logic           w_found;
    logic [N-1:0]   w_grant;
    logic           w_any;
    logic           w_load;
    logic [W-1:0]   w_ptr_next;

    // In fixed mode the search always starts from the top index.
    assign w_ptr_eff  = ROUND_ROBIN ? r_ptr : W'(N - 1);
    assign w_any      = |req;
    assign w_grant    = {{(N-1){1'b0}}, 1'b1} << w_win;
    // The source just served drops to lowest priority; index 0 wraps to N-1.
    assign w_ptr_next = (w_win == '0) ? W'(N - 1) : (w_win - 1'b1);

    // Winner search: walk ptr, ptr-1, ..., wrapping, first set request wins.
    always_comb begin : p_select
        int c;
        w_win   = '0;
        w_found = 1'b0;
        c       = 0;
        for (int k = 0; k < N; k++) begin
            c = int'(w_ptr_eff) - k;
            if (c < 0) begin
                c = c + N;
            end
            if (!w_found && req[c]) begin
                w_win   = W'(c);
                w_found = 1'b1;
            end
        end
    end

    // Next-state and load decision.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (en && w_any) begin
                    w_load       = 1'b1;
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (en && w_any) begin
                        w_load = 1'b1;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register, grant capture and rotating pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_grant <= '0;
            r_ptr   <= W'(N - 1);
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_idx   <= w_win;
                r_grant <= w_grant;
                if (ROUND_ROBIN) begin
                    r_ptr <= w_ptr_next;
                end
            end
        end
    end

    assign valid       = (r_state == HOLD);
    assign idx         = r_idx;
    assign grant       = r_grant;
    assign o_dbg_state = r_state;
    assign o_dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_priority_arb_n.sv
// tb_priority_arb_n: directed bench for priority_arb_n. Three instances:
// fixed priority N=4 (a), rotating N=4 (b), rotating N=8 (c).
module tb_priority_arb_n;

    logic clk;
    int   checks;
    int   failures;
    logic [15:0] exp_q[$];

    // Instance a: fixed priority, N=4
    logic       a_rst, a_en, a_rdy, a_valid, a_st;
    logic [3:0] a_req, a_grant;
    logic [1:0] a_idx, a_ptr;
    // Instance b: round robin, N=4
    logic       b_rst, b_en, b_rdy, b_valid, b_st;
    logic [3:0] b_req, b_grant;
    logic [1:0] b_idx, b_ptr;
    // Instance c: round robin, N=8
    logic       c_rst, c_en, c_rdy, c_valid, c_st;
    logic [7:0] c_req, c_grant;
    logic [2:0] c_idx, c_ptr;

    priority_arb_n #(.N(4), .ROUND_ROBIN(1'b0)) u_a (
        .clk(clk), .rst(a_rst), .en(a_en), .req(a_req), .out_ready(a_rdy),
        .valid(a_valid), .idx(a_idx), .grant(a_grant),
        .o_dbg_state(a_st), .o_dbg_ptr(a_ptr)
    );
    priority_arb_n #(.N(4), .ROUND_ROBIN(1'b1)) u_b (
        .clk(clk), .rst(b_rst), .en(b_en), .req(b_req), .out_ready(b_rdy),
        .valid(b_valid), .idx(b_idx), .grant(b_grant),
        .o_dbg_state(b_st), .o_dbg_ptr(b_ptr)
    );
    priority_arb_n #(.N(8), .ROUND_ROBIN(1'b1)) u_c (
        .clk(clk), .rst(c_rst), .en(c_en), .req(c_req), .out_ready(c_rdy),
        .valid(c_valid), .idx(c_idx), .grant(c_grant),
        .o_dbg_state(c_st), .o_dbg_ptr(c_ptr)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] pk(input logic v, input logic [2:0] i, input logic [7:0] g);
        return {3'b000, v, 1'b0, i, g};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input logic [15:0] e);
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag, input logic [15:0] obs);
        logic [15:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s scoreboard empty obs=%h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s obs=%h exp=%h", tag, obs, e);
            end
        end
    endtask

    function automatic logic [15:0] obs_a();
        return pk(a_valid, {1'b0, a_idx}, {4'b0000, a_grant});
    endfunction
    function automatic logic [15:0] obs_b();
        return pk(b_valid, {1'b0, b_idx}, {4'b0000, b_grant});
    endfunction
    function automatic logic [15:0] obs_c();
        return pk(c_valid, c_idx, c_grant);
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        a_rst = 1'b1; a_en = 1'b1; a_req = 4'hF; a_rdy = 1'b0;
        b_rst = 1'b1; b_en = 1'b1; b_req = 4'hF; b_rdy = 1'b0;
        c_rst = 1'b1; c_en = 1'b1; c_req = 8'hFF; c_rdy = 1'b0;

        // Reset held three cycles with all requests and enable active
        repeat (3) tick();
        expect_val(pk(1'b0, 3'd0, 8'h00)); check("rst_a", obs_a());
        expect_val(pk(1'b0, 3'd0, 8'h00)); check("rst_b", obs_b());
        expect_val(pk(1'b0, 3'd0, 8'h00)); check("rst_c", obs_c());
        expect_val(16'd7);                 check("rst_c_ptr", 16'(c_ptr));
        expect_val(16'd0);                 check("rst_c_state", 16'(c_st));

        // Release: first cycle still invalid, grant appears one edge later
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        a_en = 1'b0; a_req = 4'h0; b_en = 1'b0; b_req = 4'h0;
        expect_val(pk(1'b0, 3'd0, 8'h00)); check("rel_c_cycle0", obs_c());
        tick();
        expect_val(pk(1'b1, 3'd7, 8'h80)); check("rel_c_cycle1", obs_c());
        expect_val(16'd6);                 check("rel_c_ptr", 16'(c_ptr));
        c_en = 1'b0; c_rdy = 1'b1;
        tick();
        expect_val(pk(1'b0, 3'd7, 8'h80)); check("rel_c_accept_drop", obs_c());
        c_rdy = 1'b0;

        // Fixed priority N=4
        a_req = 4'b0101; a_en = 1'b1; a_rdy = 1'b1;
        tick();
        expect_val(pk(1'b1, 3'd2, 8'h04)); check("fix_0101", obs_a());
        a_req = 4'b0011;
        tick();
        expect_val(pk(1'b1, 3'd1, 8'h02)); check("fix_0011", obs_a());
        a_req = 4'b0000;
        tick();
        expect_val(16'd0);                 check("fix_noreq_idle", 16'(a_st));
        tick();
        expect_val(16'd0);                 check("fix_noreq_stay", 16'({15'd0, a_valid}));

        // Hold while consumer stalls, request changes underneath
        a_rdy = 1'b0; a_req = 4'b1000;
        tick();
        expect_val(pk(1'b1, 3'd3, 8'h08)); check("hold_load", obs_a());
        a_req = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_val(pk(1'b1, 3'd3, 8'h08)); check($sformatf("hold_%0d", i), obs_a());
        end
        a_rdy = 1'b1;
        tick();
        expect_val(pk(1'b1, 3'd0, 8'h01)); check("hold_release", obs_a());
        a_en = 1'b0;
        tick();
        expect_val(16'd0);                 check("hold_final_drop", 16'({15'd0, a_valid}));

        // en=0 during HOLD: held grant persists, no reload on acceptance
        a_rdy = 1'b0; a_en = 1'b1; a_req = 4'b0100;
        tick();
        expect_val(pk(1'b1, 3'd2, 8'h04)); check("en0_load", obs_a());
        a_en = 1'b0; a_req = 4'b1000;
        tick();
        expect_val(pk(1'b1, 3'd2, 8'h04)); check("en0_held", obs_a());
        a_rdy = 1'b1;
        tick();
        expect_val(16'd0);                 check("en0_drop", 16'({15'd0, a_valid}));
        expect_val(16'd3);                 check("fix_ptr_const", 16'(a_ptr));
        a_rdy = 1'b0;

        // Round robin N=4, all requests, continuous acceptance
        b_req = 4'b1111; b_en = 1'b1; b_rdy = 1'b1;
        tick();
        expect_val(pk(1'b1, 3'd3, 8'h08)); check("rr4_0", obs_b());
        tick();
        expect_val(pk(1'b1, 3'd2, 8'h04)); check("rr4_1", obs_b());
        tick();
        expect_val(pk(1'b1, 3'd1, 8'h02)); check("rr4_2", obs_b());
        tick();
        expect_val(pk(1'b1, 3'd0, 8'h01)); check("rr4_3", obs_b());
        expect_val(16'd3);                 check("rr4_wrap_ptr", 16'(b_ptr));
        tick();
        expect_val(pk(1'b1, 3'd3, 8'h08)); check("rr4_4", obs_b());
        b_en = 1'b0;
        tick();
        expect_val(16'd0);                 check("rr4_drop", 16'({15'd0, b_valid}));
        // Single-bit request wins regardless of pointer
        b_en = 1'b1; b_req = 4'b0010;
        tick();
        expect_val(pk(1'b1, 3'd1, 8'h02)); check("rr4_single", obs_b());
        tick();
        expect_val(pk(1'b1, 3'd1, 8'h02)); check("rr4_single_b2b", obs_b());
        expect_val(16'd0);                 check("rr4_single_ptr", 16'(b_ptr));
        b_en = 1'b0;
        tick();
        expect_val(16'd0);                 check("rr4_single_drop", 16'({15'd0, b_valid}));

        // Round robin N=8, req=0x81 alternates 7,0
        c_rst = 1'b1;
        tick();
        c_rst = 1'b0; c_req = 8'h81; c_en = 1'b1; c_rdy = 1'b1;
        tick();
        expect_val(pk(1'b1, 3'd7, 8'h80)); check("rr8_0", obs_c());
        tick();
        expect_val(pk(1'b1, 3'd0, 8'h01)); check("rr8_1", obs_c());
        tick();
        expect_val(pk(1'b1, 3'd7, 8'h80)); check("rr8_2", obs_c());
        tick();
        expect_val(pk(1'b1, 3'd0, 8'h01)); check("rr8_3", obs_c());
        c_en = 1'b0;
        tick();
        expect_val(16'd0);                 check("rr8_drop", 16'({15'd0, c_valid}));

        // Reset in the middle of HOLD discards the grant and the pointer
        c_en = 1'b1; c_req = 8'h20; c_rdy = 1'b0;
        tick();
        expect_val(pk(1'b1, 3'd5, 8'h20)); check("mid_hold_load", obs_c());
        expect_val(16'd4);                 check("mid_hold_ptr", 16'(c_ptr));
        c_rst = 1'b1; c_req = 8'h21;
        tick();
        expect_val(pk(1'b0, 3'd0, 8'h00)); check("mid_rst_out", obs_c());
        expect_val(16'd7);                 check("mid_rst_ptr", 16'(c_ptr));
        c_rst = 1'b0;
        tick();
        expect_val(pk(1'b1, 3'd5, 8'h20)); check("mid_rst_regrant", obs_c());

        if (exp_q.size() != 0) begin
            failures++;
            $error("FAIL scoreboard_leftover obs=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
